// File: rtl/alt_ddrx_wdata_rd_sched_pkg.sv
// Shared types and constants for the write-data read scheduler.
package alt_ddrx_wsched_pkg;

    // Default FIFO read latency: non-showahead RAM plus output register.
    localparam int unsigned WSCHED_RD_LATENCY = 2;

    // Width of the stall statistics counter.
    localparam int unsigned WSCHED_STALL_WIDTH = 16;

    // Scheduler state.
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_XFER = 1'b1
    } wsched_state_e;

    // Tag that travels alongside an issued FIFO read until its data returns.
    typedef struct packed {
        logic valid;
        logic last;
    } wsched_tag_t;

endpackage

// File: rtl/alt_ddrx_wdata_rd_sched_if.sv
// Command, FIFO and AFI write-data signals of the write-data read scheduler.
interface alt_ddrx_wdata_rd_sched_if #(
    parameter int unsigned LOCAL_DATA_WIDTH  = 32,
    parameter int unsigned LOCAL_SIZE_WIDTH  = 6,
    parameter int unsigned WDATA_BEATS_WIDTH = 9
);
    localparam int unsigned LOCAL_BE_WIDTH = LOCAL_DATA_WIDTH / 8;

    // Write burst command handshake.
    logic                          cmd_valid;
    logic [LOCAL_SIZE_WIDTH-1:0]   cmd_size;
    logic                          cmd_ready;

    // Write-data FIFO side.
    logic [WDATA_BEATS_WIDTH-1:0]  beats_in_wfifo;
    logic                          wdata_fifo_read;
    logic [LOCAL_DATA_WIDTH-1:0]   wdata_fifo_wdata;
    logic [LOCAL_BE_WIDTH-1:0]     wdata_fifo_be;

    // AFI write-data stream.
    logic                          afi_wdata_valid;
    logic [LOCAL_DATA_WIDTH-1:0]   afi_wdata;
    logic [LOCAL_BE_WIDTH-1:0]     afi_be;
    logic                          afi_wdata_last;

    // Command source, FIFO and AFI consumer.
    modport master (
        output cmd_valid, cmd_size, beats_in_wfifo, wdata_fifo_wdata, wdata_fifo_be,
        input  cmd_ready, wdata_fifo_read, afi_wdata_valid, afi_wdata, afi_be, afi_wdata_last
    );

    // The scheduler.
    modport slave (
        input  cmd_valid, cmd_size, beats_in_wfifo, wdata_fifo_wdata, wdata_fifo_be,
        output cmd_ready, wdata_fifo_read, afi_wdata_valid, afi_wdata, afi_be, afi_wdata_last
    );

endinterface

// File: rtl/alt_ddrx_wdata_rd_sched_rdpipe.sv
// Delay line carrying {valid,last} of each FIFO read until its data returns.
module alt_ddrx_wsched_rdpipe
    import alt_ddrx_wsched_pkg::*;
#(
    parameter int unsigned RD_LATENCY = WSCHED_RD_LATENCY
) (
    input  logic        ctl_clk,
    input  logic        ctl_reset_n,
    input  wsched_tag_t in_tag,
    output wsched_tag_t out_tag,
    output logic        any_valid_c
);

    if (RD_LATENCY < 1) begin : g_bad_latency
        $error("alt_ddrx_wsched_rdpipe: RD_LATENCY must be at least 1");
    end

    wsched_tag_t [RD_LATENCY-1:0] stage_q;
    wsched_tag_t [RD_LATENCY-1:0] stage_d;

    // Shift one stage per cycle; stage 0 takes the newly issued read.
    always_comb begin
        stage_d    = stage_q;
        stage_d[0] = in_tag;
        for (int i = 1; i < RD_LATENCY; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    // Pipe registers; cleared asynchronously so a reset discards in-flight beats.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            stage_q <= '0;
        end else begin
            stage_q <= stage_d;
        end
    end

    // Any issued read whose data has not yet been captured.
    always_comb begin
        any_valid_c = 1'b0;
        for (int i = 0; i < RD_LATENCY; i++) begin
            any_valid_c = any_valid_c | stage_q[i].valid;
        end
    end

    assign out_tag = stage_q[RD_LATENCY-1];

endmodule

// File: rtl/alt_ddrx_wdata_rd_sched.sv
// Write-data read scheduler: pops one FIFO beat per cycle for each accepted
// write burst while committed data exists, and realigns the returning data
// into a registered AFI write-data stream with valid/last.
// Optional feature macro: DDRX_WSCHED_STALL_CNT_EN enables the saturating
// stall_cycles counter; otherwise stall_cycles is tied to zero.
module alt_ddrx_wdata_rd_sched
    import alt_ddrx_wsched_pkg::*;
#(
    parameter int unsigned LOCAL_DATA_WIDTH  = 32,
    parameter int unsigned LOCAL_SIZE_WIDTH  = 6,
    parameter int unsigned WDATA_BEATS_WIDTH = 9,
    parameter int unsigned RD_LATENCY        = WSCHED_RD_LATENCY
) (
    input  logic                           ctl_clk,
    input  logic                           ctl_reset_n,
    alt_ddrx_wdata_rd_sched_if.slave       bus,
    output logic                           busy,
    output logic [WSCHED_STALL_WIDTH-1:0]  stall_cycles
);

    localparam int unsigned LOCAL_BE_WIDTH = LOCAL_DATA_WIDTH / 8;

    if ((LOCAL_DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("alt_ddrx_wdata_rd_sched: LOCAL_DATA_WIDTH must be a multiple of 8");
    end

    wsched_state_e                 state_q, state_d;
    logic [LOCAL_SIZE_WIDTH-1:0]   remaining_q, remaining_d;
    logic                          rd_q, rd_d;

    logic [WDATA_BEATS_WIDTH-1:0]  avail_c;
    logic                          rd_c;
    logic                          last_rd_c;
    logic                          cmd_ready_c;
    logic                          accept_c;

    wsched_tag_t                   pipe_in_c;
    wsched_tag_t                   pipe_out_c;
    logic                          pipe_busy_c;

    logic                          afi_valid_q, afi_valid_d;
    logic                          afi_last_q, afi_last_d;
    logic [LOCAL_DATA_WIDTH-1:0]   afi_wdata_q, afi_wdata_d;
    logic [LOCAL_BE_WIDTH-1:0]     afi_be_q, afi_be_d;

    // Next state, read issue and command acceptance.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        rd_c        = 1'b0;
        last_rd_c   = 1'b0;
        cmd_ready_c = 1'b0;
        accept_c    = 1'b0;
        // Occupancy lags our reads by a cycle, so discount last cycle's read.
        avail_c     = bus.beats_in_wfifo - WDATA_BEATS_WIDTH'(rd_q);

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_c = 1'b1;
                accept_c    = bus.cmd_valid;
                // Zero-length commands are consumed without any read.
                if (accept_c && (bus.cmd_size != '0)) begin
                    state_d     = ST_XFER;
                    remaining_d = bus.cmd_size;
                end
            end
            ST_XFER: begin
                rd_c = (avail_c != '0);
                if (rd_c) begin
                    remaining_d = remaining_q - LOCAL_SIZE_WIDTH'(1);
                    if (remaining_q == LOCAL_SIZE_WIDTH'(1)) begin
                        // Final beat: take the next command now so bursts run gapless.
                        last_rd_c   = 1'b1;
                        cmd_ready_c = 1'b1;
                        accept_c    = bus.cmd_valid;
                        if (accept_c && (bus.cmd_size != '0)) begin
                            remaining_d = bus.cmd_size;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rd_d = rd_c;
    end

    // Scheduler state registers.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            rd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            rd_q        <= rd_d;
        end
    end

    // Tag each read with its last flag and carry it across the FIFO latency.
    always_comb begin
        pipe_in_c       = '0;
        pipe_in_c.valid = rd_c;
        pipe_in_c.last  = last_rd_c;
    end

    alt_ddrx_wsched_rdpipe #(
        .RD_LATENCY (RD_LATENCY)
    ) u_rdpipe (
        .ctl_clk     (ctl_clk),
        .ctl_reset_n (ctl_reset_n),
        .in_tag      (pipe_in_c),
        .out_tag     (pipe_out_c),
        .any_valid_c (pipe_busy_c)
    );

    // Capture FIFO data as its tag leaves the pipe; data and BE hold otherwise.
    always_comb begin
        afi_valid_d = pipe_out_c.valid;
        afi_last_d  = pipe_out_c.valid & pipe_out_c.last;
        afi_wdata_d = afi_wdata_q;
        afi_be_d    = afi_be_q;
        if (pipe_out_c.valid) begin
            afi_wdata_d = bus.wdata_fifo_wdata;
            afi_be_d    = bus.wdata_fifo_be;
        end
    end

    // AFI output registers.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            afi_valid_q <= 1'b0;
            afi_last_q  <= 1'b0;
            afi_wdata_q <= '0;
            afi_be_q    <= '0;
        end else begin
            afi_valid_q <= afi_valid_d;
            afi_last_q  <= afi_last_d;
            afi_wdata_q <= afi_wdata_d;
            afi_be_q    <= afi_be_d;
        end
    end

`ifdef DDRX_WSCHED_STALL_CNT_EN
    logic [WSCHED_STALL_WIDTH-1:0] stall_q, stall_d;

    // Count transfer cycles without a read, saturating at all-ones.
    always_comb begin
        stall_d = stall_q;
        if ((state_q == ST_XFER) && !rd_c && (stall_q != {WSCHED_STALL_WIDTH{1'b1}})) begin
            stall_d = stall_q + WSCHED_STALL_WIDTH'(1);
        end
    end

    // Stall counter register; only reset clears it.
    always_ff @(posedge ctl_clk or negedge ctl_reset_n) begin
        if (!ctl_reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

    assign bus.cmd_ready       = cmd_ready_c;
    assign bus.wdata_fifo_read = rd_c;
    assign bus.afi_wdata_valid = afi_valid_q;
    assign bus.afi_wdata_last  = afi_last_q;
    assign bus.afi_wdata       = afi_wdata_q;
    assign bus.afi_be          = afi_be_q;
    assign busy                = (state_q != ST_IDLE) | pipe_busy_c;

    // A read in flight implies the lagging occupancy still counts that beat.
    a_no_lagged_underflow : assert property (
        @(posedge ctl_clk) disable iff (!ctl_reset_n)
        !(rd_q && (bus.beats_in_wfifo == '0))
    );

endmodule
